// File: rtl/reg_file_sequencer_if.sv
// Bundle of decoder, ROM-fetch and register-file signals around reg_file_sequencer.
// The sequencer uses the slave modport; the decoder/ROM/register-file side uses master.
interface reg_file_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic [3:0] idx;
  logic [3:0] accIn;
  logic [7:0] immIn;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] accOut;
  logic       accWe;
  logic       zeroOut;
  logic [7:0] srcAddr;
  logic       srcValid;
  logic       romReq;
  logic [7:0] romAddr;
  logic       romAck;
  logic [7:0] romData;
  logic       regWe;
  logic [3:0] regAddr;
  logic [3:0] regDin;
  logic       pairWe;
  logic [3:0] pairAddr;
  logic [7:0] pairDin;
  logic [3:0] regDout;
  logic [7:0] pairDout;

  modport slave (
    input  start, op, idx, accIn, immIn, romAck, romData, regDout, pairDout,
    output busy, done, err, accOut, accWe, zeroOut, srcAddr, srcValid,
           romReq, romAddr, regWe, regAddr, regDin, pairWe, pairAddr, pairDin
  );

  modport master (
    output start, op, idx, accIn, immIn, romAck, romData, regDout, pairDout,
    input  busy, done, err, accOut, accWe, zeroOut, srcAddr, srcValid,
           romReq, romAddr, regWe, regAddr, regDin, pairWe, pairAddr, pairDin
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// Micro-sequencer owning the 16x4 index register file: executes register-class
// instructions, runs the FIN ROM fetch handshake and pulses done on completion.
module reg_file_sequencer #(
  parameter int unsigned TIMEOUT = 8
) (
  input logic                 clk,
  input logic                 rstN,
  reg_file_sequencer_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, EXEC, ROMWAIT, WB, DONE} state_e;
  typedef enum logic [2:0] {
    OP_INC, OP_ISZ, OP_XCH, OP_LD, OP_FIM, OP_FIN, OP_SRC, OP_ILL
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [3:0]    idx_q, idx_d, acc_q, acc_d, accOut_q, accOut_d;
  logic [7:0]    imm_q, imm_d, src_q, src_d;
  logic [7:0]    romAddr_q, romAddr_d, romData_q, romData_d;
  logic          zero_q, zero_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    inc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      op_q      <= OP_INC;
      idx_q     <= '0;
      acc_q     <= '0;
      imm_q     <= '0;
      accOut_q  <= '0;
      src_q     <= '0;
      romAddr_q <= '0;
      romData_q <= '0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      imm_q     <= imm_d;
      accOut_q  <= accOut_d;
      src_q     <= src_d;
      romAddr_q <= romAddr_d;
      romData_q <= romData_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inc = bus.regDout + 4'd1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    imm_d        = imm_q;
    accOut_d     = accOut_q;
    src_d        = src_q;
    romAddr_d    = romAddr_q;
    romData_d    = romData_q;
    zero_d       = zero_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    bus.done     = 1'b0;
    bus.accWe    = 1'b0;
    bus.srcValid = 1'b0;
    bus.romReq   = 1'b0;
    bus.regWe    = 1'b0;
    bus.pairWe   = 1'b0;
    bus.regAddr  = idx_q;
    bus.regDin   = inc;
    bus.pairAddr = {idx_q[3:1], 1'b0};
    bus.pairDin  = imm_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = op_e'(bus.op);
          idx_d   = bus.idx;
          acc_d   = bus.accIn;
          imm_d   = bus.immIn;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        unique case (op_q)
          OP_INC: bus.regWe = 1'b1;
          OP_ISZ: begin
            bus.regWe = 1'b1;
            zero_d    = (inc == 4'd0);
          end
          OP_XCH: begin
            bus.regWe  = 1'b1;
            bus.regDin = acc_q;
            accOut_d   = bus.regDout;
          end
          OP_LD:  accOut_d = bus.regDout;
          OP_FIM: bus.pairWe = 1'b1;
          OP_SRC: src_d = bus.pairDout;
          // FIN reads its fetch address from pair 0 regardless of idx
          OP_FIN: begin
            bus.pairAddr = 4'd0;
            romAddr_d    = bus.pairDout;
            state_d      = ROMWAIT;
          end
          default: err_d = 1'b1;
        endcase
      end
      ROMWAIT: begin
        bus.romReq = 1'b1;
        if (bus.romAck) begin
          romData_d = bus.romData;
          state_d   = WB;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        bus.pairWe  = 1'b1;
        bus.pairDin = romData_q;
        state_d     = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.accWe    = (op_q == OP_XCH) || (op_q == OP_LD);
        bus.srcValid = (op_q == OP_SRC);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.err     = err_q;
  assign bus.accOut  = accOut_q;
  assign bus.zeroOut = zero_q;
  assign bus.srcAddr = src_q;
  assign bus.romAddr = romAddr_q;
endmodule
